spm_seq_ctrl: RTL

//  Sequencing wrapper for the serial-parallel multiplier (SPM) datapath.
//  - Front end: accepts a parallel operand pair over a valid/ready handshake.
//  - Into SPM: holds x in parallel and shifts y in serially, LSB first.
//  - Out of SPM: deserialises the serial product p into a 2*SIZE-bit signed word.
//  - Back end: presents that word on a valid/ready output.

---
 rtl/spm_pkg.sv | 15 +
 rtl/spm_seq_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier sequencing wrapper:
// FSM state encoding and default sizing parameters.
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } spmState_t;

    localparam int SPM_SIZE_DEFAULT      = 32;
    localparam int SPM_CAP_DELAY_DEFAULT = 1;

endpackage

// File: rtl/spm_seq_ctrl.sv
// Sequencing wrapper around a serial-parallel multiplier (SPM).
// Accepts a parallel operand pair, clears the SPM, holds x in parallel while
// streaming y LSB first (sign-extended to 2*SIZE bits), deserialises the
// serial product and presents the signed 2*SIZE-bit result on a valid/ready
// output. Only one product is in flight at a time.
module spm_seq_ctrl
    import spm_pkg::*;
#(
    parameter int SIZE      = SPM_SIZE_DEFAULT,
    parameter int CAP_DELAY = SPM_CAP_DELAY_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     in_x,
    input  logic [SIZE-1:0]     in_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   out_p,
    output logic                spm_rst,
    output logic [SIZE-1:0]     spm_x,
    output logic                spm_y,
    input  logic                spm_p
);

    // RUN spans 2*SIZE y bits plus the SPM capture latency; the counter has
    // one spare code so its final increment never wraps.
    localparam int RUN_LEN = 2 * SIZE + CAP_DELAY;
    localparam int CW      = $clog2(RUN_LEN + 1);

    spmState_t           r_state;
    spmState_t           w_nextState;
    logic                r_armed;
    logic [SIZE-1:0]     r_x;
    logic [SIZE-1:0]     r_yShift;
    logic [CW-1:0]       r_count;
    logic [2*SIZE-1:0]   r_prod;
    logic [2*SIZE-1:0]   r_outP;
    logic                r_spmRst;

    logic                w_inReady;
    logic                w_outValid;
    logic                w_spmY;
    logic                w_accept;
    logic                w_lastRun;
    logic                w_sample;
    logic [2*SIZE-1:0]   w_prodNext;

    assign w_accept   = in_valid & w_inReady;
    assign w_lastRun  = (r_state == RUN) && (r_count == CW'(RUN_LEN - 1));
    assign w_sample   = (r_state == RUN) && (int'(r_count) >= CAP_DELAY);
    assign w_prodNext = {spm_p, r_prod[2*SIZE-1:1]};

    // State register; reset drops straight back to IDLE, aborting any product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: IDLE -> CLEAR on accept, one CLEAR cycle, fixed-length RUN, DONE until consumed.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = CLEAR;
                end
            end
            CLEAR: begin
                w_nextState = RUN;
            end
            RUN: begin
                if (w_lastRun) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output decode: ready only in IDLE once armed, valid in DONE, serial y gated to the 2*SIZE feed window.
    always_comb begin
        w_inReady  = 1'b0;
        w_outValid = 1'b0;
        w_spmY     = 1'b0;
        case (r_state)
            IDLE: begin
                w_inReady = r_armed;
            end
            RUN: begin
                if (int'(r_count) < 2 * SIZE) begin
                    w_spmY = r_yShift[0];
                end
            end
            DONE: begin
                w_outValid = 1'b1;
            end
            default: begin
                w_inReady = 1'b0;
            end
        endcase
    end

    // Arm flag keeps in_ready low during reset and raises it on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Operand capture on accept; during RUN y shifts right with sign fill so its MSB repeats as sign extension.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_yShift <= '0;
        end else if (w_accept) begin
            r_x      <= in_x;
            r_yShift <= in_y;
        end else if (r_state == RUN) begin
            r_yShift <= {r_yShift[SIZE-1], r_yShift[SIZE-1:1]};
        end
    end

    // RUN cycle counter; held at zero outside RUN so each RUN starts from cycle 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_state == RUN) begin
            r_count <= r_count + 1'b1;
        end else begin
            r_count <= '0;
        end
    end

    // Product deserialiser: bits arrive LSB first and shift in from the top; the final word is copied out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_outP <= '0;
        end else if (w_sample) begin
            r_prod <= w_prodNext;
            if (w_lastRun) begin
                r_outP <= w_prodNext;
            end
        end
    end

    // SPM clear is registered from the next state so it is high exactly for the CLEAR cycle (and in reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spmRst <= 1'b1;
        end else begin
            r_spmRst <= (w_nextState == CLEAR);
        end
    end

    assign in_ready  = w_inReady;
    assign out_valid = w_outValid;
    assign out_p     = r_outP;
    assign spm_rst   = r_spmRst;
    assign spm_x     = r_x;
    assign spm_y     = w_spmY;

endmodule
